// File: rtl/bwt_ctrl.sv
// Block sequencer around the BWT sort core: frames the input byte stream into
// STRING_LEN-character blocks, runs the sort, then streams the result out.
module bwt_ctrl #(
  parameter int STRING_LEN = 128,
  parameter int CW         = 8,
  parameter int TIMEOUT    = 65535
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [7:0]    in_char,
  output logic          core_wr_en,
  output logic [CW-1:0] core_wr_addr,
  output logic [7:0]    core_wr_data,
  output logic          core_start,
  input  logic          core_done,
  output logic [CW-1:0] core_rd_addr,
  input  logic [7:0]    core_rd_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [7:0]    out_char,
  output logic          out_last,
  output logic          busy,
  output logic          err,
  output logic [15:0]   blk_cnt
);

  // Wait counter only ever holds 0..TIMEOUT-1 before SORT is left.
  localparam int WW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST_IDX  = CW'(STRING_LEN - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SORT, S_DRAIN} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] ld_cnt_q, ld_cnt_d;
  logic [CW-1:0] rd_cnt_q, rd_cnt_d;
  logic          rd_done_q, rd_done_d;
  logic [WW-1:0] wait_cnt_q, wait_cnt_d;
  logic          out_valid_q, out_valid_d;
  logic [7:0]    out_char_q, out_char_d;
  logic          out_last_q, out_last_d;
  logic          err_q, err_d;
  logic [15:0]   blk_cnt_q, blk_cnt_d;
  logic          accept;
  logic          timeout_hit;
  logic          out_load;
  logic          out_fire;

  assign in_ready     = (state_q == S_IDLE) || (state_q == S_LOAD);
  // Gated by rst so nothing reaches the core buffer while reset is held.
  assign accept       = in_valid && in_ready && rst;
  assign core_wr_en   = accept;
  assign core_wr_addr = ld_cnt_q;
  assign core_wr_data = in_char;
  assign core_start   = (state_q == S_SORT) && (wait_cnt_q == '0);
  assign core_rd_addr = rd_cnt_q;
  assign busy         = (state_q != S_IDLE);
  assign out_valid    = out_valid_q;
  assign out_char     = out_char_q;
  assign out_last     = out_last_q;
  assign err          = err_q | timeout_hit;
  assign blk_cnt      = blk_cnt_q;
  assign out_fire     = out_valid_q && out_ready;

  always_comb begin
    state_d     = state_q;
    ld_cnt_d    = ld_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    rd_done_d   = rd_done_q;
    wait_cnt_d  = wait_cnt_q;
    out_valid_d = out_valid_q;
    out_char_d  = out_char_q;
    out_last_d  = out_last_q;
    err_d       = err_q;
    blk_cnt_d   = blk_cnt_q;
    timeout_hit = 1'b0;
    out_load    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          ld_cnt_d = CW'(1);
          state_d  = S_LOAD;
        end
      end
      S_LOAD: begin
        if (accept) begin
          if (ld_cnt_q == LAST_IDX) begin
            ld_cnt_d   = '0;
            wait_cnt_d = '0;
            state_d    = S_SORT;
          end else begin
            ld_cnt_d = ld_cnt_q + CW'(1);
          end
        end
      end
      S_SORT: begin
        wait_cnt_d = wait_cnt_q + WW'(1);
        // A done in the start cycle cannot belong to this sort run.
        if (core_done && (wait_cnt_q != '0)) begin
          wait_cnt_d = '0;
          rd_cnt_d   = '0;
          rd_done_d  = 1'b0;
          state_d    = S_DRAIN;
        end else if (wait_cnt_q == WAIT_LAST) begin
          timeout_hit = 1'b1;
          err_d       = 1'b1;
          wait_cnt_d  = '0;
          rd_cnt_d    = '0;
          rd_done_d   = 1'b0;
          state_d     = S_DRAIN;
        end
      end
      S_DRAIN: begin
        out_load = (!out_valid_q || out_ready) && !rd_done_q;
        if (out_load) begin
          out_char_d  = core_rd_data;
          out_last_d  = (rd_cnt_q == LAST_IDX);
          out_valid_d = 1'b1;
          if (rd_cnt_q == LAST_IDX) begin
            rd_done_d = 1'b1;
          end else begin
            rd_cnt_d = rd_cnt_q + CW'(1);
          end
        end else if (out_fire) begin
          out_valid_d = 1'b0;
        end
        if (out_fire && out_last_q) begin
          blk_cnt_d = blk_cnt_q + 16'd1;
          rd_cnt_d  = '0;
          rd_done_d = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      ld_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      rd_done_q   <= 1'b0;
      wait_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      out_char_q  <= '0;
      out_last_q  <= 1'b0;
      err_q       <= 1'b0;
      blk_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      ld_cnt_q    <= ld_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      rd_done_q   <= rd_done_d;
      wait_cnt_q  <= wait_cnt_d;
      out_valid_q <= out_valid_d;
      out_char_q  <= out_char_d;
      out_last_q  <= out_last_d;
      err_q       <= err_d;
      blk_cnt_q   <= blk_cnt_d;
    end
  end

endmodule

// File: tb/tb_bwt_ctrl.sv
// Self-checking bench for bwt_ctrl: a fixed-permutation core model plus a
// scoreboard of accepted characters checks framing, ordering and handshakes.
module tb_bwt_ctrl;

  localparam int L   = 4;
  localparam int CWB = 2;
  localparam int TO  = 12;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [7:0]     in_char = 8'h00;
  logic           core_wr_en;
  logic [CWB-1:0] core_wr_addr;
  logic [7:0]     core_wr_data;
  logic           core_start;
  logic           core_done;
  logic [CWB-1:0] core_rd_addr;
  logic [7:0]     core_rd_data;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [7:0]     out_char;
  logic           out_last;
  logic           busy;
  logic           err;
  logic [15:0]    blk_cnt;

  logic model_done = 1'b0;
  logic stray_done = 1'b0;
  assign core_done = model_done | stray_done;

  always #5 clk = ~clk;

  bwt_ctrl #(.STRING_LEN(L), .CW(CWB), .TIMEOUT(TO)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_char(in_char),
    .core_wr_en(core_wr_en), .core_wr_addr(core_wr_addr), .core_wr_data(core_wr_data),
    .core_start(core_start), .core_done(core_done),
    .core_rd_addr(core_rd_addr), .core_rd_data(core_rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_char(out_char), .out_last(out_last),
    .busy(busy), .err(err), .blk_cnt(blk_cnt)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
    #1;
  endtask

  // Core model: result[i] = buffer[perm[i]] ("abcd" -> "dbca"); done after done_dly
  // cycles (0 = never, negative = random 1..10).
  int         perm [L] = '{3, 1, 2, 0};
  logic [7:0] inbuf [L];
  logic [7:0] outbuf [L];
  int         done_dly = 10;
  int         done_cnt = 0;

  assign core_rd_data = outbuf[core_rd_addr];

  always @(posedge clk) begin
    if (core_wr_en) inbuf[core_wr_addr] <= core_wr_data;
  end

  always @(posedge clk) begin
    #1;
    if (!rst) begin
      done_cnt   = 0;
      model_done = 1'b0;
    end else begin
      model_done = 1'b0;
      if (done_cnt > 0) begin
        done_cnt--;
        if (done_cnt == 0) model_done = 1'b1;
      end
      if (core_start) begin
        for (int i = 0; i < L; i++) outbuf[i] = inbuf[perm[i]];
        done_cnt = (done_dly < 0) ? int'($urandom_range(1, 10)) : done_dly;
      end
    end
  end

  // Scoreboard: accepted characters form blocks; each block is expected back permuted.
  logic [7:0] sent_q [$];
  logic [7:0] exp_q [$];
  int         hs_idx = 0;
  int         hs_total = 0;
  int         exp_blk = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_char = 8'h00;
  logic       prev_last = 1'b0;

  always @(negedge clk) begin
    logic [7:0] e;
    if (!rst) begin
      sent_q.delete();
      exp_q.delete();
      hs_idx     = 0;
      exp_blk    = 0;
      prev_stall = 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        chk("wr_en", int'(core_wr_en), 1);
        chk("wr_addr", int'(core_wr_addr), sent_q.size());
        chk("wr_data", int'(core_wr_data), int'(in_char));
        sent_q.push_back(in_char);
        if (sent_q.size() == L) begin
          for (int i = 0; i < L; i++) exp_q.push_back(sent_q[perm[i]]);
          sent_q.delete();
        end
      end else begin
        chk("wr_en_idle", int'(core_wr_en), 0);
      end
      if (prev_stall) begin
        chk("hold_valid", int'(out_valid), 1);
        chk("hold_char", int'(out_char), int'(prev_char));
        chk("hold_last", int'(out_last), int'(prev_last));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("out_spurious", int'(out_valid), 0);
        end else begin
          e = exp_q.pop_front();
          chk("out_char", int'(out_char), int'(e));
          chk("out_last", int'(out_last), int'(hs_idx == L - 1));
          $display("block %0d char %0d: out_char=%h out_last=%0d", exp_blk, hs_idx, out_char, out_last);
          hs_idx++;
          hs_total++;
          if (hs_idx == L) begin
            hs_idx = 0;
            exp_blk++;
          end
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_char  = out_char;
      prev_last  = out_last;
    end
  end

  task automatic send_block(input logic [31:0] w);
    for (int i = 0; i < L; i++) begin
      step();
      in_valid = 1'b1;
      in_char  = w[31-8*i -: 8];
      samp();
      chk("load_ready", int'(in_ready), 1);
    end
    step();
    in_valid = 1'b0;
    samp();
    chk("sort_start", int'(core_start), 1);
    chk("sort_not_ready", int'(in_ready), 0);
  endtask

  task automatic wait_idle(input int maxc);
    int n;
    n = 0;
    while (busy && n < maxc) begin
      step();
      samp();
      n++;
    end
    chk("idle_timeout", int'(busy), 0);
  endtask

  typedef struct {
    logic       iv;
    logic [7:0] ch;
    logic       exp_rdy;
    logic       exp_wr;
    logic [1:0] exp_addr;
    logic       exp_start;
    logic       exp_busy;
  } vec_t;

  vec_t tbl [9];
  logic bp [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

  initial begin
    int base;
    int n;
    int ok;
    int target;

    // Reset state
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    samp();
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_wr_en", int'(core_wr_en), 0);
    chk("rst_start", int'(core_start), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_char", int'(out_char), 0);
    chk("rst_out_last", int'(out_last), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_blk_cnt", int'(blk_cnt), 0);
    chk("rst_wr_addr", int'(core_wr_addr), 0);
    chk("rst_rd_addr", int'(core_rd_addr), 0);
    step();
    rst = 1'b1;

    // Stalled load of "abcd", then the sort start and closed input.
    tbl[0] = '{1'b1, 8'h61, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 8'h00, 1'b1, 1'b0, 2'd1, 1'b0, 1'b1};
    tbl[2] = '{1'b1, 8'h62, 1'b1, 1'b1, 2'd1, 1'b0, 1'b1};
    tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1};
    tbl[4] = '{1'b1, 8'h63, 1'b1, 1'b1, 2'd2, 1'b0, 1'b1};
    tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 2'd3, 1'b0, 1'b1};
    tbl[6] = '{1'b1, 8'h64, 1'b1, 1'b1, 2'd3, 1'b0, 1'b1};
    tbl[7] = '{1'b1, 8'h78, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1};
    tbl[8] = '{1'b1, 8'h79, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1};
    for (int i = 0; i < 9; i++) begin
      step();
      in_valid = tbl[i].iv;
      in_char  = tbl[i].ch;
      samp();
      chk($sformatf("tbl%0d_ready", i), int'(in_ready), int'(tbl[i].exp_rdy));
      chk($sformatf("tbl%0d_wr_en", i), int'(core_wr_en), int'(tbl[i].exp_wr));
      chk($sformatf("tbl%0d_wr_addr", i), int'(core_wr_addr), int'(tbl[i].exp_addr));
      chk($sformatf("tbl%0d_start", i), int'(core_start), int'(tbl[i].exp_start));
      chk($sformatf("tbl%0d_busy", i), int'(busy), int'(tbl[i].exp_busy));
    end

    // Basic drain: done in cycle 17, data on cycles 19..22, idle from 23.
    for (int c = 9; c <= 24; c++) begin
      step();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      samp();
      chk($sformatf("basic_ov_c%0d", c), int'(out_valid), int'(c >= 19 && c <= 22));
      chk("basic_no_restart", int'(core_start), 0);
      chk($sformatf("basic_busy_c%0d", c), int'(busy), int'(c <= 22));
      chk($sformatf("basic_ready_c%0d", c), int'(in_ready), int'(c >= 23));
    end
    chk("basic_blk_cnt", int'(blk_cnt), 1);

    // Output back-pressure: ready 0,0,1,0,1,1,0,1 from the first valid cycle.
    done_dly  = 3;
    out_ready = 1'b0;
    send_block("wxyz");
    base = hs_total;
    n = 0;
    while (!out_valid && n < 20) begin
      step();
      samp();
      n++;
    end
    chk("bp_first_valid", int'(out_valid), 1);
    for (int i = 0; i < 8; i++) begin
      step();
      out_ready = bp[i];
      samp();
    end
    chk("bp_handshakes", hs_total - base, 4);
    chk("bp_idle", int'(busy), 0);
    chk("bp_ready_back", int'(in_ready), 1);
    chk("bp_blk_cnt", int'(blk_cnt), exp_blk);

    // Stray core_done in IDLE and in LOAD is ignored.
    out_ready = 1'b1;
    step();
    stray_done = 1'b1;
    samp();
    step();
    stray_done = 1'b0;
    samp();
    chk("stray_idle_busy", int'(busy), 0);
    chk("stray_idle_ov", int'(out_valid), 0);
    step(); in_valid = 1'b1; in_char = 8'h70; samp();
    step(); in_char = 8'h71; samp();
    step(); in_valid = 1'b0; stray_done = 1'b1; samp();
    step(); stray_done = 1'b0; samp();
    chk("stray_load_busy", int'(busy), 1);
    chk("stray_load_ready", int'(in_ready), 1);
    chk("stray_load_addr", int'(core_wr_addr), 2);
    chk("stray_load_ov", int'(out_valid), 0);
    chk("stray_load_start", int'(core_start), 0);
    step(); in_valid = 1'b1; in_char = 8'h72; samp();
    step(); in_char = 8'h73; samp();
    step(); in_valid = 1'b0; samp();
    chk("stray_start", int'(core_start), 1);
    wait_idle(40);
    chk("stray_blk_cnt", int'(blk_cnt), exp_blk);

    // Randomized traffic on both sides with random sort latency.
    done_dly = -1;
    target = exp_blk + 20;
    ok = 0;
    for (int c = 0; c < 4000; c++) begin
      step();
      if (exp_blk >= target && !busy) begin
        in_valid = 1'b0;
        ok = 1;
        break;
      end
      in_valid  = ($urandom_range(0, 2) != 0);
      in_char   = 8'($urandom);
      out_ready = $urandom_range(0, 1) != 0;
      samp();
    end
    chk("rand_completed", ok, 1);
    chk("rand_blk_cnt", int'(blk_cnt), exp_blk);
    chk("rand_drained", exp_q.size(), 0);
    chk("rand_err", int'(err), 0);

    // Reset in the middle of DRAIN after two characters.
    done_dly  = 2;
    out_ready = 1'b1;
    step();
    send_block("lmno");
    base = hs_total;
    n = 0;
    while (hs_total - base < 2 && n < 30) begin
      step();
      samp();
      n++;
    end
    chk("rst_mid_two", hs_total - base, 2);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("rst_mid_ov", int'(out_valid), 0);
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_ready", int'(in_ready), 1);
    chk("rst_mid_blk", int'(blk_cnt), 0);
    step();
    in_valid = 1'b1;
    in_char  = 8'h55;
    samp();
    chk("rst_mid_no_wr", int'(core_wr_en), 0);
    chk("rst_mid_no_start", int'(core_start), 0);
    step();
    in_valid = 1'b0;
    rst = 1'b1;
    send_block("efgh");
    wait_idle(40);
    chk("rst_next_blk", int'(blk_cnt), 1);

    // Sort timeout: no done, err rises on the TO-th SORT cycle and stays.
    done_dly = 0;
    step();
    send_block("ijkl");
    chk("to_err_c1", int'(err), 0);
    for (int k = 2; k <= TO; k++) begin
      step();
      samp();
      chk($sformatf("to_err_c%0d", k), int'(err), int'(k == TO));
      chk("to_no_out", int'(out_valid), 0);
    end
    step();
    samp();
    chk("to_err_drain", int'(err), 1);
    chk("to_busy_drain", int'(busy), 1);
    wait_idle(40);
    chk("to_blk_cnt", int'(blk_cnt), exp_blk);
    chk("to_err_idle", int'(err), 1);
    done_dly = 3;
    send_block("mnop");
    wait_idle(40);
    chk("to_err_sticky", int'(err), 1);
    chk("to_good_blk_cnt", int'(blk_cnt), exp_blk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
